// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared constants and types for the player input frontend and the game
// stage that consumes its outputs.
//   N_PLAYERS     : number of player channels
//   CHOICE_W      : width of one player's choice switch group
//   issue_state_e : states of the pulse issue FSM
//   max2()        : small helper for sizing counters from parameters
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int N_PLAYERS = 6;
    localparam int CHOICE_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } issue_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------------------
// input_debouncer
// One button channel: 2-flop synchroniser followed by a debounce counter.
// The debounced level only flips after the synchronised input has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk     : system clock
//   reset   : synchronous active-high reset
//   i_raw   : asynchronous button input (1 = pressed)
//   o_level : debounced level
//   o_press : high in the cycle whose closing edge flips the level 0->1
// ---------------------------------------------------------------------------
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    logic w_differ;
    logic w_flip;

    assign w_differ = (r_sync2 != r_level);
    assign w_flip   = w_differ && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    // Combinational so the top can latch the choice on the very edge the
    // level rises; releases (1->0 flips) never strike.
    assign o_press = w_flip & ~r_level;

endmodule

// File: rtl/player_input_frontend.sv
// ---------------------------------------------------------------------------
// player_input_frontend
// Conditions six player buttons and their 3-bit choice switches for the
// game stage: debounced press detection, choice latching and spaced,
// fixed-width player_clk pulse groups.
// Ports:
//   clk              : system clock
//   reset            : synchronous active-high reset
//   btn_raw[5:0]     : asynchronous buttons, bit i = player i+1
//   sw_raw[17:0]     : asynchronous choice switches, [3i+2:3i] = player i+1
//   player1..player6 : latched choice of each player
//   player_clk[5:0]  : press pulses, bit i = player i+1
//   busy             : high while a pulse group or its gap is in progress
//   overrun          : one-cycle flag, a press was dropped on a pending channel
// ---------------------------------------------------------------------------
module player_input_frontend
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 4,
    parameter int GAP_CYCLES      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_PLAYERS-1:0]          btn_raw,
    input  logic [N_PLAYERS*CHOICE_W-1:0] sw_raw,
    output logic [CHOICE_W-1:0]           player1,
    output logic [CHOICE_W-1:0]           player2,
    output logic [CHOICE_W-1:0]           player3,
    output logic [CHOICE_W-1:0]           player4,
    output logic [CHOICE_W-1:0]           player5,
    output logic [CHOICE_W-1:0]           player6,
    output logic [N_PLAYERS-1:0]          player_clk,
    output logic                          busy,
    output logic                          overrun
);

    localparam int CW = $clog2(max2(PULSE_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    logic [N_PLAYERS-1:0]          w_level;
    logic [N_PLAYERS-1:0]          w_press;
    logic [N_PLAYERS-1:0]          w_accept;
    logic [N_PLAYERS-1:0]          w_drop;
    logic                          w_issue;

    logic [N_PLAYERS*CHOICE_W-1:0] r_sw_s1;
    logic [N_PLAYERS*CHOICE_W-1:0] r_sw_s2;
    logic [CHOICE_W-1:0]           r_choice [N_PLAYERS];
    logic [N_PLAYERS-1:0]          r_pending;
    logic [N_PLAYERS-1:0]          r_player_clk;
    logic                          r_busy;
    logic                          r_overrun;
    issue_state_e                  r_state;
    logic [CW-1:0]                 r_cnt;

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_chan
        input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .i_raw  (btn_raw[g]),
            .o_level(w_level[g]),
            .o_press(w_press[g])
        );

        // A strike can only come from a low debounced level.
        a_press_from_low: assert property (
            @(posedge clk) disable iff (reset) w_press[g] |-> !w_level[g]
        );
    end

    // A press on a channel that is still waiting to be issued is dropped
    // (and flagged) so the choice the game stage will see stays the first one.
    assign w_accept = w_press & ~r_pending;
    assign w_drop   = w_press &  r_pending;
    assign w_issue  = (r_state == IDLE) && (|r_pending);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_s1      <= '0;
            r_sw_s2      <= '0;
            for (int i = 0; i < N_PLAYERS; i++) begin
                r_choice[i] <= '0;
            end
            r_pending    <= '0;
            r_player_clk <= '0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
            r_state      <= IDLE;
            r_cnt        <= '0;
        end else begin
            r_sw_s1   <= sw_raw;
            r_sw_s2   <= r_sw_s1;
            r_overrun <= |w_drop;

            for (int i = 0; i < N_PLAYERS; i++) begin
                if (w_accept[i]) begin
                    r_choice[i] <= r_sw_s2[i*CHOICE_W +: CHOICE_W];
                end
            end

            // Presses accepted on the issuing edge survive into the next group.
            r_pending <= (w_issue ? '0 : r_pending) | w_accept;

            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state      <= PULSE;
                        r_player_clk <= r_pending;
                        r_busy       <= 1'b1;
                        r_cnt        <= '0;
                    end
                end
                PULSE: begin
                    if (r_cnt == PULSE_LAST) begin
                        r_state      <= GAP;
                        r_player_clk <= '0;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_player_clk <= '0;
                    r_busy       <= 1'b0;
                    r_cnt        <= '0;
                end
            endcase
        end
    end

    assign player1    = r_choice[0];
    assign player2    = r_choice[1];
    assign player3    = r_choice[2];
    assign player4    = r_choice[3];
    assign player5    = r_choice[4];
    assign player6    = r_choice[5];
    assign player_clk = r_player_clk;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_player_input_frontend.sv
// ---------------------------------------------------------------------------
// tb_player_input_frontend
// Directed bench for player_input_frontend with DEBOUNCE=4, PULSE=2, GAP=2.
// A second instance with long pulse/gap windows shares all inputs; it keeps
// a channel pending long enough for a release/re-press to hit it.
// Edge numbering in comments: E1 is the first edge that samples a new press.
// ---------------------------------------------------------------------------
module tb_player_input_frontend;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  btn_raw;
    logic [17:0] sw_raw;

    logic [2:0]  p1, p2, p3, p4, p5, p6;
    logic [5:0]  pclk;
    logic        busy, overrun;

    logic [2:0]  lp1, lp2, lp3, lp4, lp5, lp6;
    logic [5:0]  l_pclk;
    logic        l_busy, l_overrun;

    wire [25:0] main_outs = {p6, p5, p4, p3, p2, p1, pclk, busy, overrun};
    wire [25:0] long_outs = {lp6, lp5, lp4, lp3, lp2, lp1, l_pclk, l_busy, l_overrun};

    always #5 clk = ~clk;

    player_input_frontend #(
        .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(2), .GAP_CYCLES(2)
    ) u_dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .player1(p1), .player2(p2), .player3(p3), .player4(p4),
        .player5(p5), .player6(p6), .player_clk(pclk),
        .busy(busy), .overrun(overrun)
    );

    player_input_frontend #(
        .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(8), .GAP_CYCLES(8)
    ) u_dut_long (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .player1(lp1), .player2(lp2), .player3(lp3), .player4(lp4),
        .player5(lp5), .player6(lp6), .player_clk(l_pclk),
        .busy(l_busy), .overrun(l_overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving the bench 1ns past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse-rise and overrun counters for the main instance.
    int         rise_cnt [6] = '{0, 0, 0, 0, 0, 0};
    int         ovr_cnt = 0;
    logic [5:0] prev_clk = '0;

    always @(negedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (pclk[i] && !prev_clk[i]) rise_cnt[i] <= rise_cnt[i] + 1;
        end
        if (overrun) ovr_cnt <= ovr_cnt + 1;
        prev_clk <= pclk;
    end

    initial begin
        int base0, base2, base4, ovr_base, bc;

        // ---- 1. reset with random inputs ----
        reset   = 1'b1;
        btn_raw = 6'($urandom);
        sw_raw  = 18'($urandom);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check_eq("rst_outs", 32'(main_outs), 32'd0);
            btn_raw = 6'($urandom);
            sw_raw  = 18'($urandom);
        end
        reset   = 1'b0;
        btn_raw = '0;
        sw_raw  = '0;
        tick(1);
        check_eq("post_rst_outs", 32'(main_outs), 32'd0);
        tick(8);
        check_eq("idle_outs", 32'(main_outs), 32'd0);

        // ---- 2. single press latency, player3 = 5 ----
        base2 = rise_cnt[2];
        sw_raw[8:6] = 3'b101;
        btn_raw[2]  = 1'b1;
        tick(5);                                   // E5
        check_eq("t2_p3_before", 32'(p3), 32'd0);
        tick(1);                                   // E6
        check_eq("t2_p3_latched", 32'(p3), 32'd5);
        check_eq("t2_clk_e6", 32'(pclk), 32'd0);
        tick(1);                                   // E7
        check_eq("t2_clk_e7", 32'(pclk), 32'b000100);
        check_eq("t2_busy_e7", 32'(busy), 32'd1);
        tick(1);                                   // E8
        check_eq("t2_clk_e8", 32'(pclk), 32'b000100);
        tick(1);                                   // E9
        check_eq("t2_clk_e9", 32'(pclk), 32'd0);
        check_eq("t2_busy_e9", 32'(busy), 32'd1);
        tick(1);                                   // E10
        check_eq("t2_busy_e10", 32'(busy), 32'd1);
        tick(1);                                   // E11
        check_eq("t2_busy_e11", 32'(busy), 32'd0);
        tick(9);
        btn_raw[2] = 1'b0;
        tick(15);
        check_eq("t2_one_pulse", 32'(rise_cnt[2] - base2), 32'd1);
        check_eq("t2_p3_kept", 32'(p3), 32'd5);

        // ---- 3. bouncing button then steady press ----
        base0    = rise_cnt[0];
        ovr_base = ovr_cnt;
        sw_raw[2:0] = 3'b011;
        for (int k = 0; k < 3; k++) begin
            btn_raw[0] = 1'b1;
            tick(2);
            btn_raw[0] = 1'b0;
            tick(2);
        end
        check_eq("t3_no_bounce_pulse", 32'(rise_cnt[0] - base0), 32'd0);
        btn_raw[0] = 1'b1;
        tick(15);
        check_eq("t3_one_pulse", 32'(rise_cnt[0] - base0), 32'd1);
        check_eq("t3_p1", 32'(p1), 32'd3);
        check_eq("t3_no_overrun", 32'(ovr_cnt - ovr_base), 32'd0);
        btn_raw[0] = 1'b0;
        tick(10);

        // ---- 4. two players on the same edge ----
        sw_raw[2:0] = 3'b110;
        sw_raw[5:3] = 3'b001;
        btn_raw[1:0] = 2'b11;
        tick(6);                                   // E6
        check_eq("t4_p1", 32'(p1), 32'd6);
        check_eq("t4_p2", 32'(p2), 32'd1);
        check_eq("t4_clk_e6", 32'(pclk), 32'd0);
        tick(1);                                   // E7
        check_eq("t4_clk_e7", 32'(pclk), 32'b000011);
        bc = int'(busy);
        tick(1);                                   // E8
        check_eq("t4_clk_e8", 32'(pclk), 32'b000011);
        bc += int'(busy);
        tick(1);                                   // E9
        check_eq("t4_clk_e9", 32'(pclk), 32'd0);
        bc += int'(busy);
        for (int k = 0; k < 7; k++) begin
            tick(1);
            bc += int'(busy);
        end
        check_eq("t4_busy_cycles", 32'(bc), 32'd4);
        btn_raw[1:0] = 2'b00;
        tick(10);

        // Clean restart of both instances before the overrun scenario.
        reset = 1'b1;
        tick(2);
        check_eq("mid_rst_main", 32'(main_outs), 32'd0);
        check_eq("mid_rst_long", 32'(long_outs), 32'd0);
        reset = 1'b0;
        tick(2);

        // ---- 5. press during PULSE, then re-press while pending ----
        sw_raw[11:9]  = 3'b010;
        sw_raw[17:15] = 3'b100;
        btn_raw[5] = 1'b1;
        tick(2);                                   // E2
        btn_raw[3] = 1'b1;
        tick(5);                                   // E7
        check_eq("t5_clk_e7", 32'(pclk), 32'b100000);
        tick(1);                                   // E8, player4 strikes
        check_eq("t5_p4_latched", 32'(p4), 32'd2);
        check_eq("t5_lp4_latched", 32'(lp4), 32'd2);
        check_eq("t5_clk_e8", 32'(pclk), 32'b100000);
        btn_raw[3]   = 1'b0;
        sw_raw[11:9] = 3'b111;
        tick(1);                                   // E9
        check_eq("t5_clk_e9", 32'(pclk), 32'd0);
        tick(2);                                   // E11
        check_eq("t5_clk_e11", 32'(pclk), 32'd0);
        check_eq("t5_busy_e11", 32'(busy), 32'd0);
        tick(1);                                   // E12
        check_eq("t5_clk_e12", 32'(pclk), 32'b001000);
        tick(1);                                   // E13
        check_eq("t5_clk_e13", 32'(pclk), 32'b001000);
        tick(1);                                   // E14
        check_eq("t5_clk_e14", 32'(pclk), 32'd0);
        btn_raw[3] = 1'b1;
        tick(5);                                   // E19
        check_eq("t5_lovr_e19", 32'(l_overrun), 32'd0);
        tick(1);                                   // E20, second strike
        check_eq("t5_lovr_e20", 32'(l_overrun), 32'd1);
        check_eq("t5_ovr_main_e20", 32'(overrun), 32'd0);
        check_eq("t5_p4_new", 32'(p4), 32'd7);
        tick(1);                                   // E21
        check_eq("t5_lovr_e21", 32'(l_overrun), 32'd0);
        check_eq("t5_lp4_kept", 32'(lp4), 32'd2);
        check_eq("t5_clk_e21", 32'(pclk), 32'b001000);
        btn_raw = '0;
        tick(40);

        // ---- 6. reset in the middle of a PULSE with player5 pending ----
        base0 = rise_cnt[0];
        base4 = rise_cnt[4];
        sw_raw[14:12] = 3'b011;
        btn_raw[0] = 1'b1;
        tick(2);                                   // E2
        btn_raw[4] = 1'b1;
        tick(6);                                   // E8
        check_eq("t6_clk_e8", 32'(pclk), 32'b000001);
        check_eq("t6_p5_latched", 32'(p5), 32'd3);
        reset = 1'b1;
        tick(1);                                   // E9
        check_eq("t6_rst_outs", 32'(main_outs), 32'd0);
        reset   = 1'b0;
        btn_raw = '0;
        tick(20);
        check_eq("t6_no_p5_pulse", 32'(rise_cnt[4] - base4), 32'd0);
        check_eq("t6_p1_pulses", 32'(rise_cnt[0] - base0), 32'd1);
        check_eq("t6_final_outs", 32'(main_outs), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/player_input_frontend.md
Name: player_input_frontend

Overview:
Conditions the six raw player buttons and 3-bit choice switches before they reach the turn/game state machine.
Per player, it does the following:
- 2-flop synchronisation
- debounce
- press detection
- latching of the player's choice
- issuing a clean, fixed-width player_clk pulse, with the choice held stable one cycle before the pulse rises

A global lockout spaces pulse groups so the downstream stage sees one clean edge per press. Presses arriving during lockout are deferred, not lost.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive cycles a synced button must differ from its debounced level before the level flips (>=2)
PULSE_CYCLES, 4, width of each player_clk pulse in cycles (>=1)
GAP_CYCLES, 4, minimum low cycles on all player_clk bits between pulse groups (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
btn_raw  input  6  asynchronous player buttons, bit i = player i+1, 1 = pressed
sw_raw  input  18  asynchronous choice switches, bits [3i+2:3i] = player i+1
player1..player6  output  3 each  latched choice of each player, to game stage
player_clk  output  6  press pulses, bit i = player i+1, to game stage
busy  output  1  high while a pulse group or its gap is in progress
overrun  output  1  one-cycle flag: press lost because that channel was already pending

Behaviour:
Reset:
- All sync flops, debounced levels, counters, pending bits and latched choices clear to 0.
- Outputs player1..6=0, player_clk=0, busy=0, overrun=0 on the edge where reset is sampled high.
- Reset mid-pulse or mid-gap aborts immediately; pending presses are discarded.

Sync:
- btn_raw and sw_raw each pass through 2 flops: btn_s, sw_s.

Debounce, per channel:
- Counter increments each edge while btn_s != level.
- Counter clears on any edge where btn_s == level.
- When btn_s != level and the counter equals DEBOUNCE_CYCLES-1, level toggles and the counter clears.
- Glitches shorter than DEBOUNCE_CYCLES synced cycles are ignored.

Press event:
- Occurs on the edge where level toggles 0->1. Releases generate nothing.
- On a press event with pending[i]=0: set pending[i] and latch player(i+1) <= sw_s slice on the same edge.
- On a press event with pending[i]=1: choice is unchanged, event is dropped, overrun=1 for one cycle.
- A button held through reset release produces one press after debounce, since level resets to 0.

Issue FSM, states IDLE -> PULSE -> GAP -> IDLE:
- IDLE, any pending bit set: next edge enters PULSE with player_clk = pending vector; pending clears in the same edge.
- Presses arriving on that same edge stay pending for the next group.
- PULSE: player_clk held constant for exactly PULSE_CYCLES cycles, then GAP.
- GAP: player_clk=0 for exactly GAP_CYCLES cycles, then IDLE.
- Simultaneous pending players are issued together in one group. Arbitration and wrong-turn detection belong to the game stage.
- busy=1 in PULSE and GAP.
- Latched choices of channels with pending=0 never change during PULSE.

Latency:
- Idle block, btn_raw first sampled high at edge E1, then held: player choice latched at edge E(2+DEBOUNCE_CYCLES), player_clk bit rises at E(3+DEBOUNCE_CYCLES).
- Choice is therefore stable >=1 cycle before the pulse edge.

Widths:
- Debounce counter is clog2(DEBOUNCE_CYCLES) bits.
- Pulse/gap counter is clog2(max(PULSE_CYCLES,GAP_CYCLES)+1) bits.
- Counters saturate by construction; no wrap is reachable.

Decomposition:
- Package game_pkg: N_PLAYERS=6, CHOICE_W=3, issue-FSM state enum {IDLE, PULSE, GAP}. Shared with the game stage.
- One sub-module, input_debouncer (per channel: 2-flop sync plus debounce counter; outputs level and press strike), instantiated 6 times.
- Choice sync, pending bits and the issue FSM live in the top.

Test Plan (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2, GAP_CYCLES=2):
1. Reset held 3 cycles with random btn_raw/sw_raw -> all outputs 0 throughout and on the first edge after reset.
2. sw_raw player3=3'b101, btn_raw[2] high from E1 for 20 cycles -> player3=5 at E6; player_clk=6'b000100 during E7–E8; no further pulse on hold or release.
3. btn_raw[0] toggling every 2 cycles for 12 cycles, then high -> exactly one pulse on player_clk[0]; overrun stays 0.
4. btn_raw[0] and btn_raw[1] rise on the same edge -> player_clk=6'b000011 for 2 cycles; busy high 4 cycles.
5. player4 presses during PULSE -> pulse on player_clk[3] starts the cycle after GAP ends. A second player4 press (release and re-press) while still pending -> overrun=1 for one cycle and player4 keeps the first choice.
6. Reset asserted in the middle of a PULSE with player5 pending -> next edge all outputs 0; no pulse ever issued for player5.
